div512_ss_cla: RTL and testbench
================================

Name: div512_ss_cla

Overview:
- Sequential restoring (shift-subtract) divider: 512-bit dividend / 256-bit divisor, one quotient bit per enabled cycle.
- Inverse counterpart of the team's 256x256 shift-add MAC. Unpacks or checks accumulated 512-bit products, e.g. recovers A from out/B.
- Sits beside the MAC datapath and reuses the same CLA-style subtractor width for the partial remainder.

Parameters:
- DW, 512, dividend and quotient width.
- VW, 256, divisor and remainder width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  iteration enable; when 0, a running division stalls with state frozen.
- start  in  1  load request; sampled only when busy=0.
- dividend  in  DW  numerator, captured on accepted start.
- divisor  in  VW  denominator, captured on accepted start.
- busy  out  1  high from the cycle after accept until the cycle done pulses.
- done  out  1  one-cycle pulse; quotient, remainder and div_zero are valid.
- quotient  out  DW  result; held until next accepted start.
- remainder  out  VW  result; held until next accepted start.
- div_zero  out  1  divisor was 0 on the accepted start; held with results.

Behaviour:
- Reset (rst=1 at edge): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; counter and internal registers cleared. Reset mid-run aborts with no done pulse.
- States: IDLE -> RUN -> DONE -> IDLE.
- Accept: start=1 while in IDLE or DONE. en is not required for accept.
  - Captures dividend and divisor; clears partial remainder (VW+1 bits); counter=DW-1; clears div_zero.
  - If divisor!=0: go to RUN.
  - If divisor==0: go straight to DONE. quotient=all ones, remainder=dividend[VW-1:0], div_zero=1.
- start while busy=1 is ignored; operands are not re-sampled.
- RUN step (only when en=1):
  - Partial remainder P = {P[VW-1:0], dividend MSB}; dividend shifts left 1.
  - If P >= divisor: P = P - divisor, and shift 1 into the quotient LSB; else shift 0.
  - Counter decrements. When counter==0 and the step completes, go to DONE.
- RUN with en=0: no register changes; busy stays 1.
- DONE: done=1 for exactly one cycle; busy=0; results are visible in the same cycle as done. Next cycle returns to IDLE unless start is accepted in DONE (back-to-back allowed).
- Latency: accept at edge N; with en held high, done=1 during the cycle after edge N+DW+1 (513 cycles from accept to done). Each en=0 cycle in RUN adds exactly one cycle.
- Divide-by-zero latency: done during the cycle after edge N+1.
- Arithmetic:
  - Unsigned only. P is VW+1 bits, so the compare never overflows.
  - Final P[VW-1:0] is the remainder.
  - Invariant: dividend == quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
- Outputs change only on accept (cleared or div_zero values), on DONE entry (final values), or on reset.

Decomposition:
- Shared package div512_pkg: DW and VW constants; state enum {IDLE, RUN, DONE}; counter width localparam $clog2(DW).
- One natural combinational sub-module, div_step: takes P, dividend MSB and divisor; returns the next P and the quotient bit. It holds the VW+1-bit subtractor and is swappable for the CLA subtractor.
- The top holds the FSM, counter and shift registers.

Test Plan:
- dividend=1024, divisor=32, en=1 -> done 513 cycles after accept; quotient=32, remainder=0, div_zero=0.
- Sequential ops 50/10 then 10000/100, the second started in the DONE cycle of the first -> quotients 5 then 100, remainders 0. Second done arrives 513 cycles after the second accept.
- 12345/100, en toggled 0 for 7 random RUN cycles -> quotient=123, remainder=45; done delayed exactly 7 cycles. Mid-run start pulses are ignored.
- dividend=2^512-1, divisor=2^256-1 -> quotient=2^256+1, remainder=0. Dividend 2^512-1, divisor 1 -> quotient=2^512-1, remainder=0.
- divisor=0, dividend=0x1234 -> done one cycle after accept; quotient=all ones, remainder=0x1234, div_zero=1.
- rst=1 at cycle 200 of a run -> next cycle: busy=0, all outputs 0, no done. A fresh 1024/32 afterwards completes correctly.

Source files
------------

// File: rtl/div512_ss_cla_pkg.sv
// Shared constants, FSM state encoding and small helpers for the 512/256 divider.
// Pure declarations, no timing.
// Not applicable: no handshake lives here.
package div512_pkg;

    // Dividend / quotient width and divisor / remainder width.
    localparam int PKG_DW = 512;
    localparam int PKG_VW = 256;

    // Iteration counter width; one count per quotient bit.
    localparam int PKG_CW = $clog2(PKG_DW);

    // IDLE: waiting for start. RUN: one quotient bit per enabled cycle.
    // DONE: one wrap-up cycle that publishes the results and pulses done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width for an arbitrary dividend width, never narrower than 1 bit.
    function automatic int cnt_width(input int dw);
        return (dw > 2) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/div512_ss_cla_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module div_step
    import div512_pkg::*;
#(
    parameter int VW = PKG_VW
) (
    input  logic [VW:0]   p_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   p_o,
    output logic          q_o
);

    // Partial remainder after the left shift.
    logic [VW:0]   shifted;
    // One extra bit on top catches the borrow of the trial subtraction.
    logic [VW+1:0] diff;

    // The subtractor is isolated here so a CLA implementation can replace it
    // without touching the control path. A clear borrow means shifted >= divisor.
    always_comb begin
        shifted = {p_i[VW-1:0], bit_i};
        diff    = {1'b0, shifted} - {2'b00, divisor_i};
        q_o     = ~diff[VW+1];
        p_o     = q_o ? diff[VW:0] : shifted;
    end

endmodule

// File: rtl/div512_ss_cla.sv
// Sequential restoring divider, 512-bit dividend by 256-bit divisor, one quotient bit per enabled cycle.
// 513 cycles from accepted start to done with en held high; each en=0 cycle in RUN adds one; divide-by-zero takes 1.
// start is only accepted while not busy; en=0 freezes a running division.
module div512_ss_cla
    import div512_pkg::*;
#(
    parameter int DW = PKG_DW,
    parameter int VW = PKG_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = cnt_width(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    // Holds the remaining dividend bits in the upper end while quotient bits
    // enter at the LSB; after DW steps it holds the full quotient.
    logic [DW-1:0] work_q;
    logic [VW:0]   p_q;
    logic [VW-1:0] dvs_q;

    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;
    logic          div_zero_q;

    logic [VW:0]   p_d;
    logic          q_bit_d;

    div_step #(
        .VW (VW)
    ) u_step (
        .p_i       (p_q),
        .bit_i     (work_q[DW-1]),
        .divisor_i (dvs_q),
        .p_o       (p_d),
        .q_o       (q_bit_d)
    );

    // FSM, iteration datapath and registered outputs in one sequential block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            p_q         <= '0;
            dvs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Accept does not need en; the done cycle is also IDLE,
                    // which is what makes back-to-back operation possible.
                    if (start) begin
                        dvs_q  <= divisor;
                        cnt_q  <= CNT_LAST;
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            // Preload the working registers with the fixed
                            // divide-by-zero answer so DONE publishes it unchanged.
                            work_q      <= '1;
                            p_q         <= {1'b0, dividend[VW-1:0]};
                            quotient_q  <= '1;
                            remainder_q <= dividend[VW-1:0];
                            div_zero_q  <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            work_q      <= dividend;
                            p_q         <= '0;
                            quotient_q  <= '0;
                            remainder_q <= '0;
                            div_zero_q  <= 1'b0;
                            state_q     <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A stalled cycle leaves every register untouched.
                    if (en) begin
                        p_q    <= p_d;
                        work_q <= {work_q[DW-2:0], q_bit_d};
                        cnt_q  <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results and done appear together; busy drops in the same cycle.
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    quotient_q  <= work_q;
                    remainder_q <= p_q[VW-1:0];
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div512_ss_cla.sv
// Directed self-checking bench for div512_ss_cla.
// Outputs are sampled on the falling edge or #1 after the rising edge.
// Each scenario is a task with its own inline comparisons.
module tb_div512_ss_cla;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         start;
    logic [511:0] dividend;
    logic [255:0] divisor;
    logic         busy;
    logic         done;
    logic [511:0] quotient;
    logic [255:0] remainder;
    logic         div_zero;

    int errs   = 0;
    int checks = 0;

    bit stall_mode = 1'b0;
    bit pulse_mode = 1'b0;
    int stall_list [7] = '{5, 6, 40, 41, 200, 333, 480};

    div512_ss_cla dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic bit is_stall(input int c);
        bit hit = 1'b0;
        foreach (stall_list[i]) begin
            if (stall_list[i] == c) hit = 1'b1;
        end
        return hit;
    endfunction

    // Called on a falling edge; returns #1 after the accepting rising edge.
    task automatic launch(input logic [511:0] a, input logic [255:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts rising edges after the accept edge until done is seen.
    task automatic wait_done(output int cyc);
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 1500) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                en = (stall_mode && is_stall(cyc + 1)) ? 1'b0 : 1'b1;
                if (pulse_mode && (cyc == 100 || cyc == 250)) begin
                    start    = 1'b1;
                    dividend = 512'd999;
                    divisor  = 256'd7;
                end else begin
                    start = 1'b0;
                end
            end
        end
        en    = 1'b1;
        start = 1'b0;
        checks++;
        if (!seen) begin
            errs++;
            $display("FAIL wait_done: no done pulse within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        en       = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (div_zero !== 1'b0) begin errs++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        checks++; if (quotient !== 512'd0) begin errs++; $display("FAIL reset_quotient: got %h want 0", quotient); end
        checks++; if (remainder !== 256'd0) begin errs++; $display("FAIL reset_remainder: got %h want 0", remainder); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        launch(512'd1024, 256'd32);
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_after_accept: got %b want 1", busy); end
        wait_done(cyc);
        checks++; if (cyc != 513) begin errs++; $display("FAIL basic_latency: got %0d want 513", cyc); end
        checks++; if (quotient !== 512'd32) begin errs++; $display("FAIL basic_quotient: got %0d want 32", quotient); end
        checks++; if (remainder !== 256'd0) begin errs++; $display("FAIL basic_remainder: got %0d want 0", remainder); end
        checks++; if (div_zero !== 1'b0) begin errs++; $display("FAIL basic_div_zero: got %b want 0", div_zero); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL basic_done_width: got %b want 0", done); end
        checks++; if (quotient !== 512'd32) begin errs++; $display("FAIL basic_quotient_hold: got %0d want 32", quotient); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        launch(512'd50, 256'd10);
        wait_done(cyc);
        checks++; if (cyc != 513) begin errs++; $display("FAIL b2b_first_latency: got %0d want 513", cyc); end
        checks++; if (quotient !== 512'd5) begin errs++; $display("FAIL b2b_first_quotient: got %0d want 5", quotient); end
        checks++; if (remainder !== 256'd0) begin errs++; $display("FAIL b2b_first_remainder: got %0d want 0", remainder); end
        // Start the second division in the done cycle of the first.
        launch(512'd10000, 256'd100);
        checks++; if (quotient !== 512'd0) begin errs++; $display("FAIL b2b_clear_on_accept: got %0d want 0", quotient); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_busy: got %b want 1", busy); end
        wait_done(cyc);
        checks++; if (cyc != 513) begin errs++; $display("FAIL b2b_second_latency: got %0d want 513", cyc); end
        checks++; if (quotient !== 512'd100) begin errs++; $display("FAIL b2b_second_quotient: got %0d want 100", quotient); end
        checks++; if (remainder !== 256'd0) begin errs++; $display("FAIL b2b_second_remainder: got %0d want 0", remainder); end
    endtask

    task automatic test_stall;
        int cyc;
        stall_mode = 1'b1;
        pulse_mode = 1'b1;
        launch(512'd12345, 256'd100);
        wait_done(cyc);
        stall_mode = 1'b0;
        pulse_mode = 1'b0;
        checks++; if (cyc != 520) begin errs++; $display("FAIL stall_latency: got %0d want 520", cyc); end
        checks++; if (quotient !== 512'd123) begin errs++; $display("FAIL stall_quotient: got %0d want 123", quotient); end
        checks++; if (remainder !== 256'd45) begin errs++; $display("FAIL stall_remainder: got %0d want 45", remainder); end
    endtask

    task automatic test_extremes;
        int cyc;
        logic [511:0] all_d;
        logic [255:0] all_v;
        logic [511:0] q_exp;
        all_d = '1;
        all_v = '1;
        q_exp = (512'd1 << 256) + 512'd1;
        launch(all_d, all_v);
        wait_done(cyc);
        checks++; if (quotient !== q_exp) begin errs++; $display("FAIL max_by_max_quotient: got %h want %h", quotient, q_exp); end
        checks++; if (remainder !== 256'd0) begin errs++; $display("FAIL max_by_max_remainder: got %h want 0", remainder); end
        launch(all_d, 256'd1);
        wait_done(cyc);
        checks++; if (cyc != 513) begin errs++; $display("FAIL max_by_one_latency: got %0d want 513", cyc); end
        checks++; if (quotient !== all_d) begin errs++; $display("FAIL max_by_one_quotient: got %h want %h", quotient, all_d); end
        checks++; if (remainder !== 256'd0) begin errs++; $display("FAIL max_by_one_remainder: got %h want 0", remainder); end
    endtask

    task automatic test_div_zero;
        int cyc;
        logic [511:0] all_d;
        all_d = '1;
        launch(512'h1234, 256'd0);
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL dz_busy_after_accept: got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL dz_done_early: got %b want 0", done); end
        wait_done(cyc);
        checks++; if (cyc != 1) begin errs++; $display("FAIL dz_latency: got %0d want 1", cyc); end
        checks++; if (quotient !== all_d) begin errs++; $display("FAIL dz_quotient: got %h want all ones", quotient); end
        checks++; if (remainder !== 256'h1234) begin errs++; $display("FAIL dz_remainder: got %h want 1234", remainder); end
        checks++; if (div_zero !== 1'b1) begin errs++; $display("FAIL dz_flag: got %b want 1", div_zero); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL dz_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (div_zero !== 1'b1) begin errs++; $display("FAIL dz_flag_hold: got %b want 1", div_zero); end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        bit early_done;
        bit bad_idle;
        early_done = 1'b0;
        bad_idle   = 1'b0;
        launch(512'd1024, 256'd32);
        checks++; if (div_zero !== 1'b0) begin errs++; $display("FAIL mid_dz_cleared_on_accept: got %b want 0", div_zero); end
        for (int i = 0; i < 199; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) early_done = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (early_done) begin errs++; $display("FAIL mid_no_early_done: got done before reset"); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL mid_done: got %b want 0", done); end
        checks++; if (quotient !== 512'd0) begin errs++; $display("FAIL mid_quotient: got %h want 0", quotient); end
        checks++; if (remainder !== 256'd0) begin errs++; $display("FAIL mid_remainder: got %h want 0", remainder); end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad_idle = 1'b1;
        end
        checks++; if (bad_idle) begin errs++; $display("FAIL mid_aborted_stays_idle: got done or busy after reset"); end
        launch(512'd1024, 256'd32);
        wait_done(cyc);
        checks++; if (cyc != 513) begin errs++; $display("FAIL mid_rerun_latency: got %0d want 513", cyc); end
        checks++; if (quotient !== 512'd32) begin errs++; $display("FAIL mid_rerun_quotient: got %0d want 32", quotient); end
        checks++; if (remainder !== 256'd0) begin errs++; $display("FAIL mid_rerun_remainder: got %0d want 0", remainder); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_extremes();
        test_div_zero();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
